// File: rtl/e1_pkg.sv
// Shared constants for the E1 TX BD autoload sequencer: status word bit map,
// BD word field positions and the access-cycle state encoding.
package e1_pkg;

    // Status/control word bit positions (read with m_addr_lsb = 0)
    localparam int STAT_UNDERFLOW_BIT = 12;
    localparam int STAT_BTO_FULL_BIT  = 11;
    localparam int STAT_BTO_EMPTY_BIT = 10;
    localparam int STAT_BTI_FULL_BIT  = 9;
    localparam int STAT_BTI_EMPTY_BIT = 8;

    // BD word field positions (m_addr_lsb = 1)
    localparam int BD_VALID_BIT  = 15;
    localparam int BD_CRC_HI_BIT = 14;
    localparam int BD_CRC_LO_BIT = 13;

    // Access-cycle FSM encoding; each bus access is an A/B pair
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STAT_A = 3'd1;
    localparam logic [2:0] S_STAT_B = 3'd2;
    localparam logic [2:0] S_RDBD_A = 3'd3;
    localparam logic [2:0] S_RDBD_B = 3'd4;
    localparam logic [2:0] S_WRBD_A = 3'd5;
    localparam logic [2:0] S_WRBD_B = 3'd6;

endpackage

// File: rtl/e1_tx_bd_ring_ptr.sv
// Ring offset counter: counts 0..i_last and wraps, presenting the slot
// number i_base + offset truncated to MFW bits.
module e1_tx_bd_ring_ptr #(
    parameter int MFW = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clr,
    input  logic           i_adv,
    input  logic [MFW-1:0] i_base,
    input  logic [MFW-1:0] i_last,
    output logic [MFW-1:0] o_slot
);

    logic [MFW-1:0] r_off;

    // Offset advances on each use and returns to zero after the last ring slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_off <= '0;
        end else if (i_clr) begin
            r_off <= '0;
        end else if (i_adv) begin
            r_off <= (r_off == i_last) ? '0 : r_off + MFW'(1);
        end
    end

    // Slot wraps modulo 2^MFW naturally through truncation
    assign o_slot = i_base + r_off;

endmodule

// File: rtl/e1_tx_bd_autoload.sv
// E1 TX BD autoload: bus master of the TX submodule port that submits filled
// multiframe slots into BD-in and reclaims completions from BD-out.
module e1_tx_bd_autoload
    import e1_pkg::*;
#(
    parameter int MFW = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_ena,
    input  logic [MFW-1:0] cfg_mf_base,
    input  logic [MFW-1:0] cfg_mf_last,
    input  logic [1:0]     cfg_crc_e,
    input  logic           host_push,
    output logic           m_addr_sel,
    output logic           m_addr_lsb,
    output logic           m_we,
    output logic           m_clr,
    output logic [15:0]    m_wdata,
    input  logic [15:0]    m_rdata,
    output logic           done_stb,
    output logic [MFW-1:0] done_mf,
    output logic [MFW:0]   credits,
    output logic [MFW:0]   inflight,
    output logic           err_seq,
    output logic           err_ovf,
    output logic           underflow
);

    localparam logic [MFW:0] ONE = (MFW+1)'(1);

    logic [2:0]     r_state;
    logic [2:0]     w_nxt;
    logic           r_bto_empty;
    logic           r_bti_full;
    logic           w_clr;
    logic           w_submit;
    logic           w_done;
    logic           w_full;
    logic           w_push_ok;
    logic [MFW:0]   w_occ;
    logic [MFW:0]   w_ring_size;
    logic [MFW-1:0] w_sub_slot;
    logic [MFW-1:0] w_exp_slot;
    logic [15:0]    w_bd_word;
    logic           w_unused_rdata;

    // Enabling from IDLE restarts the ring bookkeeping from scratch
    assign w_clr       = (r_state == S_IDLE) && cfg_ena;
    assign w_submit    = (r_state == S_WRBD_A);
    assign w_done      = (r_state == S_RDBD_A) && m_rdata[BD_VALID_BIT];
    assign w_occ       = credits + inflight;
    assign w_ring_size = {1'b0, cfg_mf_last} + ONE;
    assign w_full      = (w_occ >= w_ring_size);
    assign w_push_ok   = host_push && !w_full;
    assign w_unused_rdata = ^m_rdata;

    e1_tx_bd_ring_ptr #(.MFW(MFW)) u_sub_ptr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_adv  (w_submit),
        .i_base (cfg_mf_base),
        .i_last (cfg_mf_last),
        .o_slot (w_sub_slot)
    );

    e1_tx_bd_ring_ptr #(.MFW(MFW)) u_exp_ptr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_adv  (w_done),
        .i_base (cfg_mf_base),
        .i_last (cfg_mf_last),
        .o_slot (w_exp_slot)
    );

    // BD word for the next submit: valid clear, E-bits, slot number
    always_comb begin
        w_bd_word = '0;
        w_bd_word[BD_CRC_HI_BIT:BD_CRC_LO_BIT] = cfg_crc_e;
        w_bd_word[MFW-1:0] = w_sub_slot;
    end

    // Next access: reclaim beats submit; a low enable drains after the B cycle
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (cfg_ena) w_nxt = S_STAT_A;
            S_STAT_A: w_nxt = S_STAT_B;
            S_STAT_B: begin
                if (!cfg_ena)                         w_nxt = S_IDLE;
                else if (!r_bto_empty)                w_nxt = S_RDBD_A;
                else if (!r_bti_full && credits != '0) w_nxt = S_WRBD_A;
                else                                  w_nxt = S_STAT_A;
            end
            S_RDBD_A: w_nxt = S_RDBD_B;
            S_WRBD_A: w_nxt = S_WRBD_B;
            S_RDBD_B,
            S_WRBD_B: w_nxt = cfg_ena ? S_STAT_A : S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // State register and bus outputs, decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            m_addr_sel <= 1'b0;
            m_addr_lsb <= 1'b0;
            m_we       <= 1'b0;
            m_clr      <= 1'b1;
            m_wdata    <= '0;
        end else begin
            r_state <= w_nxt;
            case (w_nxt)
                S_STAT_A, S_RDBD_A, S_WRBD_A: begin
                    m_addr_sel <= 1'b1;
                    m_clr      <= 1'b0;
                    m_addr_lsb <= (w_nxt != S_STAT_A);
                    m_we       <= (w_nxt == S_WRBD_A);
                    m_wdata    <= (w_nxt == S_WRBD_A) ? w_bd_word : 16'h0000;
                end
                S_IDLE: begin
                    m_addr_sel <= 1'b0;
                    m_clr      <= 1'b1;
                    m_addr_lsb <= 1'b0;
                    m_we       <= 1'b0;
                    m_wdata    <= '0;
                end
                default: begin
                    // B cycle: target latches write data late, so m_wdata holds
                    m_addr_sel <= 1'b0;
                    m_clr      <= 1'b1;
                    m_we       <= 1'b0;
                end
            endcase
        end
    end

    // Status latch taken during the status read cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bto_empty <= 1'b1;
            r_bti_full  <= 1'b1;
            underflow   <= 1'b0;
        end else if (r_state == S_STAT_A) begin
            r_bto_empty <= m_rdata[STAT_BTO_EMPTY_BIT];
            r_bti_full  <= m_rdata[STAT_BTI_FULL_BIT];
            underflow   <= m_rdata[STAT_UNDERFLOW_BIT];
        end
    end

    // Completion strobe, completed slot and out-of-order detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_stb <= 1'b0;
            done_mf  <= '0;
            err_seq  <= 1'b0;
        end else begin
            done_stb <= w_done;
            if (w_done) done_mf <= m_rdata[MFW-1:0];
            if (w_clr)
                err_seq <= 1'b0;
            else if (w_done && (m_rdata[MFW-1:0] != w_exp_slot))
                err_seq <= 1'b1;
        end
    end

    // Credit and in-flight accounting; pushes beyond ring capacity are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits  <= '0;
            inflight <= '0;
            err_ovf  <= 1'b0;
        end else if (w_clr) begin
            credits  <= '0;
            inflight <= '0;
            err_ovf  <= 1'b0;
        end else begin
            case ({w_push_ok, w_submit})
                2'b10:   credits <= credits + ONE;
                2'b01:   credits <= credits - ONE;
                default: credits <= credits;
            endcase
            if (host_push && w_full) err_ovf <= 1'b1;
            if (w_submit)
                inflight <= inflight + ONE;
            else if (w_done && inflight != '0)
                inflight <= inflight - ONE;
        end
    end

endmodule

// File: tb/tb_e1_tx_bd_autoload.sv
// Directed bench for e1_tx_bd_autoload with a minimal TX submodule model
// answering status and BD-out reads and a monitor logging BD writes.
module tb_e1_tx_bd_autoload;

    localparam int MFW = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_ena;
    logic [MFW-1:0] cfg_mf_base;
    logic [MFW-1:0] cfg_mf_last;
    logic [1:0]     cfg_crc_e;
    logic           host_push;
    logic           m_addr_sel;
    logic           m_addr_lsb;
    logic           m_we;
    logic           m_clr;
    logic [15:0]    m_wdata;
    logic [15:0]    m_rdata;
    logic           done_stb;
    logic [MFW-1:0] done_mf;
    logic [MFW:0]   credits;
    logic [MFW:0]   inflight;
    logic           err_seq;
    logic           err_ovf;
    logic           underflow;

    logic [15:0] tb_stat;
    logic [15:0] tb_bdo;
    logic [15:0] wr_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cnt_sel;
    int cnt_we;
    int cnt_lsb;

    always #5 clk = ~clk;

    e1_tx_bd_autoload #(.MFW(MFW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_ena     (cfg_ena),
        .cfg_mf_base (cfg_mf_base),
        .cfg_mf_last (cfg_mf_last),
        .cfg_crc_e   (cfg_crc_e),
        .host_push   (host_push),
        .m_addr_sel  (m_addr_sel),
        .m_addr_lsb  (m_addr_lsb),
        .m_we        (m_we),
        .m_clr       (m_clr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .done_stb    (done_stb),
        .done_mf     (done_mf),
        .credits     (credits),
        .inflight    (inflight),
        .err_seq     (err_seq),
        .err_ovf     (err_ovf),
        .underflow   (underflow)
    );

    // TX submodule model: combinational read data for status or BD-out
    assign m_rdata = m_addr_lsb ? tb_bdo : tb_stat;

    // Log every BD written during its A cycle
    always @(negedge clk) begin
        if (m_addr_sel && m_we) wr_q.push_back(m_wdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1();
        host_push = 1'b1;
        tick(1);
        host_push = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done_stb === 1'b1) got = 1'b1;
        end
        chk(tag, {31'b0, got}, 32'd1);
    endtask

    task automatic wait_we(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_we === 1'b1) got = 1'b1;
        end
        chk(tag, {31'b0, got}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; cfg_ena = 1'b0; host_push = 1'b0;
        cfg_mf_base = 7'd8; cfg_mf_last = 7'd3; cfg_crc_e = 2'b10;
        tb_stat = 16'h0400; tb_bdo = 16'h0000;
        tick(1);
        chk("rst_sel", m_addr_sel, 0);
        chk("rst_clr", m_clr, 1);
        chk("rst_we", m_we, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_done", done_stb, 0);
        chk("rst_credits", credits, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_errs", {err_seq, err_ovf, underflow}, 0);
        rst = 1'b0;
        tick(1);

        // Enable, one push, first submit three cycles later
        cfg_ena = 1'b1;
        tick(1);
        chk("stat_a_sel", m_addr_sel, 1);
        chk("stat_a_clr", m_clr, 0);
        chk("stat_a_lsb", m_addr_lsb, 0);
        host_push = 1'b1;
        tick(1);
        host_push = 1'b0;
        chk("stat_b_sel", m_addr_sel, 0);
        chk("stat_b_clr", m_clr, 1);
        chk("credits_1", credits, 1);
        tick(1);
        chk("wrbd_a_sel", m_addr_sel, 1);
        chk("wrbd_a_we", m_we, 1);
        chk("wrbd_a_lsb", m_addr_lsb, 1);
        chk("wrbd_a_wdata", m_wdata, 16'h4008);
        tick(1);
        chk("wrbd_b_sel", m_addr_sel, 0);
        chk("wrbd_b_we", m_we, 0);
        chk("wrbd_b_wdata_hold", m_wdata, 16'h4008);
        chk("credits_0", credits, 0);
        chk("inflight_1", inflight, 1);

        // Four more pushes; the last lands with the ring full and is dropped
        host_push = 1'b1;
        tick(4);
        host_push = 1'b0;
        chk("ovf_set", err_ovf, 1);
        chk("ovf_credits", credits, 2);
        chk("ovf_inflight", inflight, 2);
        tick(12);
        chk("fill_credits", credits, 0);
        chk("fill_inflight", inflight, 4);
        chk("fill_count", wr_q.size(), 4);
        chk("fill_w0", wr_q[0], 16'h4008);
        chk("fill_w1", wr_q[1], 16'h4009);
        chk("fill_w2", wr_q[2], 16'h400A);
        chk("fill_w3", wr_q[3], 16'h400B);

        // Model completes slots 8 and 9
        tb_stat = 16'h0000; tb_bdo = 16'h8008;
        wait_done("done1_to");
        chk("done1_mf", done_mf, 8);
        chk("done1_inflight", inflight, 3);
        tb_bdo = 16'h8009;
        tick(1);
        chk("done_pulse", done_stb, 0);
        wait_done("done2_to");
        chk("done2_mf", done_mf, 9);
        chk("done2_inflight", inflight, 2);
        chk("seq_ok", err_seq, 0);
        tb_stat = 16'h0400;

        // Two pushes reuse slots 8 and 9 after the offset wrap
        wr_q.delete();
        host_push = 1'b1;
        tick(2);
        host_push = 1'b0;
        tick(14);
        chk("wrap_count", wr_q.size(), 2);
        chk("wrap_w0", wr_q[0], 16'h4008);
        chk("wrap_w1", wr_q[1], 16'h4009);
        chk("wrap_inflight", inflight, 4);
        chk("ovf_sticky", err_ovf, 1);

        // Drain, then ring at base 126 with BD-in full
        cfg_ena = 1'b0;
        tick(4);
        chk("drain_sel", m_addr_sel, 0);
        chk("drain_clr", m_clr, 1);
        cfg_mf_base = 7'd126; cfg_mf_last = 7'd3; cfg_crc_e = 2'b01;
        tb_stat = 16'h0600;
        wr_q.delete();
        cfg_ena = 1'b1;
        tick(1);
        chk("reen_ovf_clr", err_ovf, 0);
        chk("reen_inflight", inflight, 0);
        host_push = 1'b1;
        tick(3);
        host_push = 1'b0;
        chk("full_credits", credits, 3);
        cnt_sel = 0; cnt_we = 0; cnt_lsb = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (m_addr_sel) cnt_sel++;
            if (m_we) cnt_we++;
            if (m_addr_sel && m_addr_lsb) cnt_lsb++;
        end
        chk("poll_sel", cnt_sel, 8);
        chk("poll_we", cnt_we, 0);
        chk("poll_lsb", cnt_lsb, 0);
        chk("poll_nowrite", wr_q.size(), 0);
        tb_stat = 16'h1600;
        tick(4);
        chk("underflow_set", underflow, 1);
        tb_stat = 16'h0400;
        push1();
        tick(24);
        chk("mod_count", wr_q.size(), 4);
        chk("mod_w0", wr_q[0], 16'h207E);
        chk("mod_w1", wr_q[1], 16'h207F);
        chk("mod_w2", wr_q[2], 16'h2000);
        chk("mod_w3", wr_q[3], 16'h2001);
        chk("mod_credits", credits, 0);
        chk("mod_inflight", inflight, 4);
        chk("underflow_clr", underflow, 0);

        // Out-of-order completion: slot 5 returned while slot 4 expected
        cfg_ena = 1'b0;
        tick(4);
        cfg_mf_base = 7'd4; cfg_mf_last = 7'd3; cfg_crc_e = 2'b00;
        wr_q.delete();
        cfg_ena = 1'b1;
        tick(1);
        push1();
        tick(8);
        chk("seq_wr_count", wr_q.size(), 1);
        chk("seq_wr", wr_q[0], 16'h0004);
        tb_stat = 16'h0000; tb_bdo = 16'h8005;
        wait_done("seq_done_to");
        chk("seq_mf", done_mf, 5);
        chk("seq_err", err_seq, 1);
        chk("seq_inflight", inflight, 0);
        tb_stat = 16'h0400;
        tick(6);
        chk("seq_sticky", err_seq, 1);
        cfg_ena = 1'b0;
        tick(4);
        chk("seq_sticky_off", err_seq, 1);
        cfg_ena = 1'b1;
        tick(1);
        chk("seq_clr", err_seq, 0);

        // Disable during WRBD_A: B cycle completes, then IDLE
        push1();
        wait_we("dis_we_to");
        cfg_ena = 1'b0;
        tick(1);
        chk("dis_b_sel", m_addr_sel, 0);
        chk("dis_b_clr", m_clr, 1);
        chk("dis_b_wdata", m_wdata, 16'h0004);
        tick(1);
        chk("dis_idle_clr", m_clr, 1);
        tick(3);
        chk("dis_idle_sel", m_addr_sel, 0);
        chk("dis_inflight", inflight, 1);

        // Async reset during WRBD_A releases the bus at once
        cfg_ena = 1'b1;
        tick(1);
        push1();
        wait_we("rst_we_to");
        rst = 1'b1;
        #1;
        chk("arst_sel", m_addr_sel, 0);
        chk("arst_clr", m_clr, 1);
        chk("arst_we", m_we, 0);
        chk("arst_wdata", m_wdata, 0);
        chk("arst_inflight", inflight, 0);
        chk("arst_done_mf", done_mf, 0);
        tick(1);
        rst = 1'b0;
        cfg_ena = 1'b0;
        tick(2);
        chk("post_rst_sel", m_addr_sel, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
